// File: rtl/lane_collector.sv
// lane_collector: collects lane-routed sample bits from an upstream 3-state
// router into per-lane shift registers and emits full W-bit words over a
// valid/ready output with round-robin arbitration between full lanes.
// Optional feature: define LANE_COLLECTOR_PARITY_EN to add the even-parity
// output out_par, registered alongside out_data.
module lane_collector #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   q_in,
  input  logic         s_in,
  input  logic         smp,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_lane,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         ovf,
`ifdef LANE_COLLECTOR_PARITY_EN
  output logic         err,
  output logic         out_par
`else
  output logic         err
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } lane_e;

  // (a + b) mod 3 for lane indices in 0..2
  function automatic logic [1:0] lane_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // One-hot mask of the bit a sample may legally carry; none for the unused encoding
  function automatic logic [2:0] lane_mask(input logic [1:0] l);
    logic [2:0] m;
    case (l)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  lane_e        lp_q, lp_d;
  logic [1:0]   rr_q, rr_d;
  logic [W-1:0] sr_q  [3];
  logic [W-1:0] sr_d  [3];
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [W-1:0] out_data_q, out_data_d;
  logic [1:0]   out_lane_q, out_lane_d;
  logic         out_vld_q, out_vld_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
`ifdef LANE_COLLECTOR_PARITY_EN
  logic         out_par_q, out_par_d;
`endif

  logic         loadable;
  logic [2:0]   full;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;
  logic [W-1:0] gnt_word;
  logic         smp_bit;

  // Lane pointer: mirror of the upstream router's state machine
  always_comb begin
    lp_d = lp_q;
    case (lp_q)
      LANE0:   lp_d = s_in ? LANE1 : LANE0;
      LANE1:   lp_d = s_in ? LANE2 : LANE0;
      LANE2:   lp_d = s_in ? LANE0 : LANE2;
      default: lp_d = LANE0;
    endcase
  end

  // Round-robin grant among full lanes, starting the search at rr
  always_comb begin
    loadable = !out_vld_q || out_rdy;
    for (int k = 0; k < 3; k++) begin
      full[k] = (cnt_q[k] == CW'(W));
    end
    gnt_vld  = 1'b0;
    gnt_idx  = rr_q;
    gnt_word = '0;
    if (loadable) begin
      // Walk from farthest to nearest so the lane closest to rr wins
      for (int i = 2; i >= 0; i--) begin
        if (full[lane_add(rr_q, 2'(i))]) begin
          gnt_vld = 1'b1;
          gnt_idx = lane_add(rr_q, 2'(i));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (gnt_idx == 2'(k)) gnt_word = sr_q[k];
    end
  end

  // Lane shift registers, counts, sticky flags and output register next state
  always_comb begin
    smp_bit    = |q_in;
    rr_d       = rr_q;
    out_data_d = out_data_q;
    out_lane_d = out_lane_q;
    out_vld_d  = out_vld_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
`ifdef LANE_COLLECTOR_PARITY_EN
    out_par_d  = out_par_q;
`endif
    for (int k = 0; k < 3; k++) begin
      sr_d[k]  = sr_q[k];
      cnt_d[k] = cnt_q[k];
    end

    if (smp && ((q_in & ~lane_mask(lp_q)) != 3'b000)) err_d = 1'b1;

    for (int k = 0; k < 3; k++) begin
      if (gnt_vld && (gnt_idx == 2'(k))) cnt_d[k] = '0;
      if (smp && (lp_q == 2'(k))) begin
        if (full[k] && !(gnt_vld && (gnt_idx == 2'(k)))) begin
          // Lane full and not draining: drop the sample
          ovf_d = 1'b1;
        end else begin
          sr_d[k]  = {sr_q[k][W-2:0], smp_bit};
          // A sample into the lane being drained starts the next word
          cnt_d[k] = (gnt_vld && (gnt_idx == 2'(k))) ? CW'(1) : cnt_q[k] + CW'(1);
        end
      end
    end

    if (gnt_vld) begin
      out_data_d = gnt_word;
      out_lane_d = gnt_idx;
      out_vld_d  = 1'b1;
      rr_d       = lane_add(gnt_idx, 2'd1);
`ifdef LANE_COLLECTOR_PARITY_EN
      out_par_d  = ^gnt_word;
`endif
    end else if (loadable) begin
      out_vld_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q       <= LANE0;
      rr_q       <= 2'd0;
      out_data_q <= '0;
      out_lane_q <= 2'd0;
      out_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef LANE_COLLECTOR_PARITY_EN
      out_par_q  <= 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
        sr_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      lp_q       <= lp_d;
      rr_q       <= rr_d;
      out_data_q <= out_data_d;
      out_lane_q <= out_lane_d;
      out_vld_q  <= out_vld_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
`ifdef LANE_COLLECTOR_PARITY_EN
      out_par_q  <= out_par_d;
`endif
      for (int k = 0; k < 3; k++) begin
        sr_q[k]  <= sr_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign out_data = out_data_q;
  assign out_lane = out_lane_q;
  assign out_vld  = out_vld_q;
  assign ovf      = ovf_q;
  assign err      = err_q;
`ifdef LANE_COLLECTOR_PARITY_EN
  assign out_par  = out_par_q;
`endif

endmodule
